line_buffer_feeder: RTL
=======================

Name: line_buffer_feeder

Overview:
Write-side front end for the line buffer.
- Accepts a raster pixel stream from the pre-processing stage over a valid/ready handshake.
- Generates the line buffer's write enable, write address, data, end-of-line and read-advance strobes.
- Tracks how many lines are filled and flags a valid vertical window once NUM_LINES-1 full lines are resident.
- Polices line length and frame framing so the line buffer's internal line rotation never desynchronises from the image.

Parameters:
DATA_WIDTH, 16, pixel width in bits (8..32); must match the line buffer.
NUM_LINES, 4, number of line memories in the line buffer.
LINE_WIDTH, 640, pixels per line (1..16384).
ADDR_WIDTH, 14, line buffer address width; LINE_WIDTH <= 2**ADDR_WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
s_valid  in  1  upstream pixel valid.
s_ready  out  1  feeder can accept a pixel.
s_data  in  DATA_WIDTH  pixel value.
s_sof  in  1  first pixel of frame, qualified by s_valid.
s_eol  in  1  last pixel of line, qualified by s_valid.
lb_we  out  1  line buffer write enable.
lb_wr_addr  out  ADDR_WIDTH  line buffer write column.
lb_data  out  DATA_WIDTH  line buffer write data.
lb_eol  out  1  line buffer end-of-line strobe (rotates write line, clears read address).
lb_ready  out  1  line buffer read-address advance.
window_valid  out  1  line buffer data_out holds a valid NUM_LINES-tall column.
primed  out  1  NUM_LINES-1 lines of the current frame are filled.
err_short  out  1  sticky: s_eol seen before column LINE_WIDTH-1.
err_long  out  1  sticky: column LINE_WIDTH-1 reached without s_eol.
err_sof  out  1  sticky: s_sof accepted while mid-line.

Behaviour:
- Reset: state IDLE; all outputs 0, including s_ready; col=0; line_cnt=0; error flags cleared. Reset asserted mid-frame abandons the frame with no lb_eol.
- Accept = s_valid & s_ready.
- All lb_* outputs are registered and follow the accepted beat by one cycle: lb_we=1, lb_wr_addr=col, lb_data=s_data.
- col increments per accept and wraps to 0 after each line end.
- lb_eol asserts in the same cycle as the write of the line's last pixel. That write lands in the old line; the rotation takes effect on the next line.
- States:
  - IDLE: s_ready=1. Non-sof beats are dropped. A sof beat is written (col 0) and the state moves to FILL.
  - FILL: s_ready=1. At each line end, line_cnt++. When line_cnt reaches NUM_LINES-1, set primed and move to STREAM.
  - STREAM: s_ready=1. lb_ready=lb_we, so the read address tracks the write column. window_valid=lb_ready delayed 1 cycle (BRAM read latency). line_cnt stays saturated.
  - DISCARD: s_ready=1. Accepted beats produce no write. A beat with s_eol returns to FILL or STREAM per primed.
  - RESYNC: s_ready=0 for exactly 1 cycle. Emits lb_eol with lb_we=0.
- Short line: s_eol at col<LINE_WIDTH-1 ends the line normally and sets err_short.
- Long line: at col==LINE_WIDTH-1 with s_eol=0, the beat is written, lb_eol is forced, err_long is set and the state goes to DISCARD.
  - s_eol and col==LINE_WIDTH-1 together is the normal case, not an error.
- Mid-frame sof, col!=0: the sof beat is not accepted. The feeder enters RESYNC, then accepts the sof beat as col 0 of a new frame with line_cnt=0, primed=0, state FILL. err_sof is set.
- Mid-frame sof, col==0: frame restarts directly, no RESYNC, no error.
- sof together with eol is a 1-pixel line: write, lb_eol, line_cnt=1.
- Error flags clear only on rst.

Optional Feature:
LB_FEEDER_STATS_EN
- Defined: adds outputs stat_frames[15:0] (sof beats accepted) and stat_drops[15:0] (beats dropped in IDLE or DISCARD). Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package lb_pkg:
  - state encodings IDLE/FILL/STREAM/DISCARD/RESYNC;
  - ADDR_WIDTH default 14;
  - DATA_WIDTH range limits.
  - The line buffer and this block both use lb_pkg.
- Sub-module lb_col_counter: column counter with wrap at LINE_WIDTH-1 and a last-column flag; reusable by the line buffer read side.

Test Plan:
- Reset, then 4 lines of 8 pixels (LINE_WIDTH=8, first beat sof) -> 32 writes at addr 0..7. lb_eol on addr 7 each line. primed after line 3. lb_ready during line 4 only. window_valid lags lb_ready by 1.
- Short line: s_eol at pixel 5 (LINE_WIDTH=8) -> lb_eol on addr 5, err_short=1, next line starts at addr 0.
- Long line: 11 pixels, eol on the 11th -> writes addr 0..7, lb_eol at addr 7, err_long=1. 3 beats dropped with no lb_we. Next line starts at addr 0.
- sof at col 3 -> s_ready=0 one cycle, lb_eol alone. sof pixel written at addr 0, primed=0, err_sof=1.
- Non-sof beats after reset -> dropped, no lb_we. With LB_FEEDER_STATS_EN defined: stat_drops counts them and stat_frames=1 after the first sof.
- rst asserted mid-line -> all outputs 0 asynchronously. Next sof restarts at addr 0 with no lb_eol.

Source files
------------

// File: rtl/lb_pkg.sv
// Definitions shared by the line buffer and its write-side feeder: state encoding,
// default address width and supported pixel widths.
package lb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    STREAM  = 3'd2,
    DISCARD = 3'd3,
    RESYNC  = 3'd4
  } lb_state_e;

  localparam int LB_ADDR_WIDTH     = 14;
  localparam int LB_DATA_WIDTH_MIN = 8;
  localparam int LB_DATA_WIDTH_MAX = 32;

endpackage

// File: rtl/line_buffer_feeder_if.sv
// Raster pixel stream into the line buffer feeder: valid/ready with sof/eol framing.
interface line_buffer_feeder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_sof;
  logic                  s_eol;

  modport master (output s_valid, s_data, s_sof, s_eol, input s_ready);
  modport slave  (input s_valid, s_data, s_sof, s_eol, output s_ready);
endinterface

// File: rtl/lb_col_counter.sv
// Column counter for one line: wraps after LINE_WIDTH-1 and flags the last column.
module lb_col_counter
  import lb_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] col,
  output logic                  last
);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_WIDTH - 1);

  assign last = (col == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) col <= '0;
    else if (clr || (inc && last)) col <= '0;
    else if (inc) col <= col + 1'b1;
  end
endmodule

// File: rtl/line_buffer_feeder.sv
// Write-side front end of the line buffer: frames the pixel stream into line writes and
// tracks line fill. Define LB_FEEDER_STATS_EN to add frame/drop statistics outputs.
//
// state   | meaning
// IDLE    | waiting for sof; other beats dropped
// FILL    | writing lines, fewer than NUM_LINES-1 resident
// STREAM  | primed; read address follows the write column
// DISCARD | overlong line closed early, dropping beats up to its eol
// RESYNC  | mid-line sof held off one cycle while the partial line is closed
module line_buffer_feeder
  import lb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LINES  = 4,
  parameter int LINE_WIDTH = 640,
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  line_buffer_feeder_if.slave   s,
  output logic                  lb_we,
  output logic [ADDR_WIDTH-1:0] lb_wr_addr,
  output logic [DATA_WIDTH-1:0] lb_data,
  output logic                  lb_eol,
  output logic                  lb_ready,
  output logic                  window_valid,
  output logic                  primed,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_sof
`ifdef LB_FEEDER_STATS_EN
  ,
  output logic [15:0]           stat_frames,
  output logic [15:0]           stat_drops
`endif
);
  localparam int CNT_W = $clog2(NUM_LINES + 1);
  localparam logic [CNT_W-1:0] PRIME_CNT = CNT_W'(NUM_LINES - 1);

  lb_state_e state, state_nxt, st_eff;
  logic ready_q;
  logic [ADDR_WIDTH-1:0] col;
  logic last_col, col_inc, col_clr;
  logic [CNT_W-1:0] line_cnt, cnt_nxt, base_cnt;
  logic primed_nxt, base_primed;
  logic sof_mid, accept, start, write, line_end;
  logic we_nxt, eol_nxt, rdy_nxt, set_short, set_long, set_sof, drop;

  lb_col_counter #(.LINE_WIDTH(LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_col (
    .clk (clk),
    .rst (rst),
    .inc (col_inc),
    .clr (col_clr),
    .col (col),
    .last(last_col)
  );

  // A sof arriving mid-line is refused and the FSM takes the RESYNC branch for this cycle.
  assign sof_mid     = ready_q & s.s_valid & s.s_sof & (col != '0);
  assign st_eff      = sof_mid ? RESYNC : state;
  assign s.s_ready   = ready_q & ~sof_mid;
  assign accept      = s.s_valid & s.s_ready;
  assign start       = accept & s.s_sof;
  assign write       = accept & (s.s_sof | (state == FILL) | (state == STREAM));
  assign line_end    = s.s_eol | last_col;
  assign base_cnt    = start ? '0 : line_cnt;
  assign base_primed = start ? 1'b0 : primed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = line_cnt;
    primed_nxt = primed;
    we_nxt     = 1'b0;
    eol_nxt    = 1'b0;
    rdy_nxt    = 1'b0;
    col_inc    = 1'b0;
    col_clr    = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    set_sof    = 1'b0;
    drop       = 1'b0;
    case (st_eff)
      RESYNC: begin
        eol_nxt    = 1'b1;
        col_clr    = 1'b1;
        cnt_nxt    = '0;
        primed_nxt = 1'b0;
        set_sof    = 1'b1;
        state_nxt  = FILL;
      end
      default: begin
        if (write) begin
          we_nxt     = 1'b1;
          rdy_nxt    = base_primed;
          eol_nxt    = line_end;
          col_inc    = 1'b1;
          col_clr    = s.s_eol;
          set_short  = s.s_eol & ~last_col;
          set_long   = last_col & ~s.s_eol;
          cnt_nxt    = base_cnt;
          primed_nxt = base_primed;
          state_nxt  = base_primed ? STREAM : FILL;
          if (line_end && !base_primed) begin
            cnt_nxt = base_cnt + 1'b1;
            if (cnt_nxt == PRIME_CNT) begin
              primed_nxt = 1'b1;
              state_nxt  = STREAM;
            end
          end
          if (set_long) state_nxt = DISCARD;
        end else if (accept) begin
          drop = 1'b1;
          if (state == DISCARD && s.s_eol) state_nxt = primed ? STREAM : FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q      <= 1'b0;
      line_cnt     <= '0;
      primed       <= 1'b0;
      lb_we        <= 1'b0;
      lb_wr_addr   <= '0;
      lb_data      <= '0;
      lb_eol       <= 1'b0;
      lb_ready     <= 1'b0;
      window_valid <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_sof      <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      line_cnt     <= cnt_nxt;
      primed       <= primed_nxt;
      lb_we        <= we_nxt;
      lb_eol       <= eol_nxt;
      lb_ready     <= rdy_nxt;
      window_valid <= lb_ready;
      if (we_nxt) begin
        lb_wr_addr <= col;
        lb_data    <= s.s_data;
      end
      err_short <= err_short | set_short;
      err_long  <= err_long | set_long;
      err_sof   <= err_sof | set_sof;
    end
  end

`ifdef LB_FEEDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames <= '0;
      stat_drops  <= '0;
    end else begin
      if (start && stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
      if (drop && stat_drops != 16'hFFFF) stat_drops <= stat_drops + 16'd1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = drop;
`endif
endmodule
